// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALUControl codes for the long-latency ops and
// the multi-cycle sequencer state encoding plus op-class decode helpers.
package pipeline_pkg;

  localparam int ALUCONTROL_WIDTH = 6;

  localparam logic [ALUCONTROL_WIDTH-1:0] MUL   = 6'b100111;
  localparam logic [ALUCONTROL_WIDTH-1:0] MLA   = 6'b101000;
  localparam logic [ALUCONTROL_WIDTH-1:0] MLS   = 6'b101001;
  localparam logic [ALUCONTROL_WIDTH-1:0] UMULL = 6'b101010;
  localparam logic [ALUCONTROL_WIDTH-1:0] UMLAL = 6'b101011;
  localparam logic [ALUCONTROL_WIDTH-1:0] SMULL = 6'b101100;
  localparam logic [ALUCONTROL_WIDTH-1:0] SMLAL = 6'b101101;
  localparam logic [ALUCONTROL_WIDTH-1:0] UDIV  = 6'b101110;
  localparam logic [ALUCONTROL_WIDTH-1:0] SDIV  = 6'b101111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } md_state_e;

  function automatic logic is_muldiv_op(input logic [ALUCONTROL_WIDTH-1:0] op);
    case (op)
      MUL, MLA, MLS, UMULL, UMLAL, SMULL, SMLAL, UDIV, SDIV: is_muldiv_op = 1'b1;
      default: is_muldiv_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [ALUCONTROL_WIDTH-1:0] op);
    case (op)
      UDIV, SDIV: is_div_op = 1'b1;
      default:    is_div_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_wide_op(input logic [ALUCONTROL_WIDTH-1:0] op);
    case (op)
      UMULL, UMLAL, SMULL, SMLAL: is_wide_op = 1'b1;
      default:                    is_wide_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [ALUCONTROL_WIDTH-1:0] op);
    case (op)
      SMULL, SMLAL, SDIV: is_signed_op = 1'b1;
      default:            is_signed_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter_unit.sv
// Radix-2 iteration datapath shared by multiply (shift-add) and divide
// (restoring shift-subtract); {hi,lo} holds product or {remainder,quotient}.
module muldiv_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] opnd_a,
  input  logic [XLEN-1:0] opnd_b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_r, lo_r, next_hi_s, next_lo_s;
  logic [XLEN:0]   add_s, mul_s, rem_s, diff_s;

  // One iteration step; a set diff_s MSB means the trial subtraction borrowed
  always_comb begin
    add_s  = {1'b0, hi_r} + {1'b0, opnd_a};
    mul_s  = lo_r[0] ? add_s : {1'b0, hi_r};
    rem_s  = {hi_r, lo_r[XLEN-1]};
    diff_s = rem_s - {1'b0, opnd_b};
    if (is_div) begin
      if (!diff_s[XLEN]) begin
        next_hi_s = diff_s[XLEN-1:0];
        next_lo_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        next_hi_s = rem_s[XLEN-1:0];
        next_lo_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      next_hi_s = mul_s[XLEN:1];
      next_lo_s = {mul_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Working register: load seeds multiplier or dividend into the low half
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_r <= {XLEN{1'b0}};
      lo_r <= {XLEN{1'b0}};
    end else if (load) begin
      hi_r <= {XLEN{1'b0}};
      lo_r <= is_div ? opnd_a : opnd_b;
    end else if (step) begin
      hi_r <= next_hi_s;
      lo_r <= next_lo_s;
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/MLA/MLS/xMULL/xMLAL/xDIV sequencer beside the E-stage ALU:
// FSM, iteration counter, sign/accumulate fix-up and result registers.
module muldiv_sequencer
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = ALUCONTROL_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [OPW-1:0]  op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [XLEN-1:0] acc_lo_i,
  input  logic [XLEN-1:0] acc_hi_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            wide_o,
  output logic [XLEN-1:0] res_lo_o,
  output logic [XLEN-1:0] res_hi_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  md_state_e         state_r, next_state_s;
  logic [OPW-1:0]    op_r;
  logic [XLEN-1:0]   a_r, b_r, acc_lo_r, acc_hi_r;
  logic [CW-1:0]     cnt_r;
  logic [XLEN-1:0]   res_lo_r, res_hi_r;
  logic              wide_r;
  logic              accept_s, div_s, sgn_s, neg_s, div_zero_s, load_s, step_s;
  logic [XLEN-1:0]   abs_a_s, abs_b_s, p_hi_s, p_lo_s;
  logic [2*XLEN-1:0] prod_s, fix_s;

  // Operand decode: magnitudes and result sign come from the latched operands
  always_comb begin
    accept_s   = (state_r == ST_IDLE) & start_i & is_muldiv_op(op_i) & ~flush_i;
    div_s      = is_div_op(op_r);
    sgn_s      = is_signed_op(op_r);
    abs_a_s    = (sgn_s & a_r[XLEN-1]) ? ({XLEN{1'b0}} - a_r) : a_r;
    abs_b_s    = (sgn_s & b_r[XLEN-1]) ? ({XLEN{1'b0}} - b_r) : b_r;
    neg_s      = sgn_s & (a_r[XLEN-1] ^ b_r[XLEN-1]);
    div_zero_s = div_s & (b_r == {XLEN{1'b0}});
    load_s     = (state_r == ST_SETUP);
    step_s     = (state_r == ST_ITER);
  end

  muldiv_iter_unit #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (load_s),
    .step   (step_s),
    .is_div (div_s),
    .opnd_a (abs_a_s),
    .opnd_b (abs_b_s),
    .hi     (p_hi_s),
    .lo     (p_lo_s)
  );

  // Fix-up: negating the full 64 bits also yields the negated quotient in lo
  always_comb begin
    prod_s = neg_s ? ({(2*XLEN){1'b0}} - {p_hi_s, p_lo_s}) : {p_hi_s, p_lo_s};
    case (op_r)
      MUL, UDIV, SDIV: fix_s = {{XLEN{1'b0}}, prod_s[XLEN-1:0]};
      MLA:             fix_s = {{XLEN{1'b0}}, prod_s[XLEN-1:0] + acc_lo_r};
      MLS:             fix_s = {{XLEN{1'b0}}, acc_lo_r - prod_s[XLEN-1:0]};
      UMULL, SMULL:    fix_s = prod_s;
      UMLAL, SMLAL:    fix_s = prod_s + {acc_hi_r, acc_lo_r};
      default:         fix_s = {(2*XLEN){1'b0}};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic; flush aborts every busy state except DONE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  next_state_s = accept_s ? ST_SETUP : ST_IDLE;
      ST_SETUP: if (flush_i)         next_state_s = ST_IDLE;
                else if (div_zero_s) next_state_s = ST_DONE;
                else                 next_state_s = ST_ITER;
      ST_ITER:  if (flush_i)                 next_state_s = ST_IDLE;
                else if (cnt_r == LAST_ITER) next_state_s = ST_FIX;
                else                         next_state_s = ST_ITER;
      ST_FIX:   next_state_s = flush_i ? ST_IDLE : ST_DONE;
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Status outputs; stall is low in DONE so E captures the result
  always_comb begin
    busy_o = (state_r != ST_IDLE);
    done_o = (state_r == ST_DONE);
    case (state_r)
      ST_IDLE:                    stall_o = accept_s;
      ST_SETUP, ST_ITER, ST_FIX:  stall_o = ~flush_i;
      default:                    stall_o = 1'b0;
    endcase
  end

  // Operand capture at acceptance; later start_i pulses cannot disturb it
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_r     <= {OPW{1'b0}};
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      acc_lo_r <= {XLEN{1'b0}};
      acc_hi_r <= {XLEN{1'b0}};
    end else if (accept_s) begin
      op_r     <= op_i;
      a_r      <= a_i;
      b_r      <= b_i;
      acc_lo_r <= acc_lo_i;
      acc_hi_r <= acc_hi_i;
    end
  end

  // Iteration counter
  always_ff @(posedge clk) begin
    if (!reset)                 cnt_r <= {CW{1'b0}};
    else if (state_r == ST_SETUP) cnt_r <= {CW{1'b0}};
    else if (state_r == ST_ITER)  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
  end

  // Result registers hold until the next completed op or reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      res_lo_r <= {XLEN{1'b0}};
      res_hi_r <= {XLEN{1'b0}};
      wide_r   <= 1'b0;
    end else if ((state_r == ST_FIX) && !flush_i) begin
      res_lo_r <= fix_s[XLEN-1:0];
      res_hi_r <= fix_s[2*XLEN-1:XLEN];
      wide_r   <= is_wide_op(op_r);
    end else if ((state_r == ST_SETUP) && !flush_i && div_zero_s) begin
      res_lo_r <= {XLEN{1'b0}};
      res_hi_r <= {XLEN{1'b0}};
      wide_r   <= 1'b0;
    end
  end

  assign res_lo_o = res_lo_r;
  assign res_hi_o = res_hi_r;
  assign wide_o   = wide_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: latency, results,
// divide-by-zero, flush, mid-op reset and start held while busy.
module tb_muldiv_sequencer;
  import pipeline_pkg::*;

  logic        clk = 1'b0, reset = 1'b0, start_i = 1'b0, flush_i = 1'b0;
  logic [5:0]  op_i = 6'd0;
  logic [31:0] a_i = 32'd0, b_i = 32'd0, acc_lo_i = 32'd0, acc_hi_i = 32'd0;
  logic        stall_o, busy_o, done_o, wide_o;
  logic [31:0] res_lo_o, res_hi_o;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start_i(start_i), .flush_i(flush_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .acc_lo_i(acc_lo_i), .acc_hi_i(acc_hi_i),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o), .wide_o(wide_o),
    .res_lo_o(res_lo_o), .res_hi_o(res_hi_o)
  );

  // Issues one op and waits (bounded) for done_o; lat = cycles from accept to done.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, b, al, ah,
                        output logic [31:0] lo, hi, output logic wide,
                        output int lat, output int stall_bad);
    stall_bad = 0; lat = 0; lo = 32'd0; hi = 32'd0; wide = 1'b0;
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; acc_lo_i = al; acc_hi_i = ah; start_i = 1'b1;
    #1;
    if (stall_o !== 1'b1) stall_bad++;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      if (done_o === 1'b1) begin
        lat = c; lo = res_lo_o; hi = res_hi_o; wide = wide_o;
        if (stall_o !== 1'b0) stall_bad++;
        break;
      end
      if (stall_o !== 1'b1) stall_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    n_checks++; if (wide_o !== 1'b0) begin n_fail++; $display("FAIL reset_wide: got %b want 0", wide_o); end
    n_checks++; if (res_lo_o !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", res_lo_o); end
    n_checks++; if (res_hi_o !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", res_hi_o); end
    reset = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] lo, hi; logic w; int lat, sb;
    run_op(MUL, 32'd7, 32'd6, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lat != 35) begin n_fail++; $display("FAIL mul_latency: got %0d want 35", lat); end
    n_checks++; if (sb != 0) begin n_fail++; $display("FAIL mul_stall: got %0d bad cycles want 0", sb); end
    n_checks++; if (lo !== 32'd42) begin n_fail++; $display("FAIL mul_lo: got %h want 0000002a", lo); end
    n_checks++; if (w !== 1'b0) begin n_fail++; $display("FAIL mul_wide: got %b want 0", w); end
    run_op(MLA, 32'd3, 32'd4, 32'd10, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lo !== 32'd22) begin n_fail++; $display("FAIL mla_lo: got %h want 00000016", lo); end
    run_op(MLS, 32'd3, 32'd4, 32'd10, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mls_lo: got %h want fffffffe", lo); end
    run_op(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lo !== 32'd1) begin n_fail++; $display("FAIL mul_neg_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_wide();
    logic [31:0] lo, hi; logic w; int lat, sb;
    run_op(SMULL, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE) begin n_fail++; $display("FAIL smull: got %h_%h want ffffffff_fffffffe", hi, lo); end
    n_checks++; if (w !== 1'b1) begin n_fail++; $display("FAIL smull_wide: got %b want 1", w); end
    run_op(UMLAL, 32'hFFFFFFFF, 32'd2, 32'd1, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if ({hi, lo} !== 64'h00000001_FFFFFFFF) begin n_fail++; $display("FAIL umlal: got %h_%h want 00000001_ffffffff", hi, lo); end
    run_op(UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin n_fail++; $display("FAIL umull: got %h_%h want fffffffe_00000001", hi, lo); end
    run_op(SMLAL, 32'hFFFFFFFD, 32'd5, 32'd20, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if ({hi, lo} !== 64'h00000000_00000005) begin n_fail++; $display("FAIL smlal: got %h_%h want 00000000_00000005", hi, lo); end
    n_checks++; if (lat != 35) begin n_fail++; $display("FAIL smlal_latency: got %0d want 35", lat); end
  endtask

  task automatic test_div();
    logic [31:0] lo, hi; logic w; int lat, sb;
    run_op(SDIV, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL sdiv_neg7_2: got %h want fffffffd", lo); end
    n_checks++; if (w !== 1'b0) begin n_fail++; $display("FAIL sdiv_wide: got %b want 0", w); end
    run_op(UDIV, 32'd100, 32'd7, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL udiv_100_7: got %h want 0000000e", lo); end
    n_checks++; if (lat != 35) begin n_fail++; $display("FAIL udiv_latency: got %0d want 35", lat); end
    run_op(SDIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL sdiv_min_m1: got %h want 80000000", lo); end
    run_op(SDIV, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL sdiv_7_neg2: got %h want fffffffd", lo); end
    run_op(UDIV, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lo !== 32'h55555555) begin n_fail++; $display("FAIL udiv_max_3: got %h want 55555555", lo); end
  endtask

  task automatic test_div_zero();
    logic [31:0] lo, hi; logic w; int lat, sb;
    run_op(UDIV, 32'd5, 32'd0, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL divzero_latency: got %0d want 2", lat); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL divzero_lo: got %h want 0", lo); end
    n_checks++; if (sb != 0) begin n_fail++; $display("FAIL divzero_stall: got %0d bad cycles want 0", sb); end
    @(negedge clk); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL divzero_busy_after: got %b want 0", busy_o); end
  endtask

  task automatic test_flush();
    int dones = 0, done_at = 0;
    @(negedge clk);
    op_i = MUL; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); start_i = 1'b0; #1;
      if (done_o === 1'b1) dones++;
    end
    @(negedge clk); flush_i = 1'b1; #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall_same: got %b want 0", stall_o); end
    @(negedge clk); flush_i = 1'b0; #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall_next: got %b want 0", stall_o); end
    @(negedge clk); start_i = 1'b1; a_i = 32'd11; b_i = 32'd12; #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL flush_restart_stall: got %b want 1", stall_o); end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); start_i = 1'b0; #1;
      if (done_o === 1'b1) begin
        dones++;
        if (done_at == 0) done_at = c;
        n_checks++; if (res_lo_o !== 32'd132) begin n_fail++; $display("FAIL flush_restart_lo: got %h want 00000084", res_lo_o); end
      end
    end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL flush_done_count: got %0d want 1", dones); end
    n_checks++; if (done_at != 35) begin n_fail++; $display("FAIL flush_restart_latency: got %0d want 35", done_at); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] lo, hi; logic w; int lat, sb; int dones = 0;
    run_op(SMULL, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, lo, hi, w, lat, sb);
    n_checks++; if (w !== 1'b1) begin n_fail++; $display("FAIL pre_reset_wide: got %b want 1", w); end
    @(negedge clk);
    op_i = UMULL; a_i = 32'd3; b_i = 32'd3; start_i = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk); start_i = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk); reset = 1'b1; #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b want 0", stall_o); end
    n_checks++; if (wide_o !== 1'b0) begin n_fail++; $display("FAIL midreset_wide: got %b want 0", wide_o); end
    n_checks++; if ({res_hi_o, res_lo_o} !== 64'd0) begin n_fail++; $display("FAIL midreset_res: got %h_%h want 0", res_hi_o, res_lo_o); end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done_o === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midreset_done: got %0d pulses want 0", dones); end
  endtask

  task automatic test_back_to_back();
    int dones = 0, done_at = 0;
    logic [31:0] lo = 32'd0;
    @(negedge clk);
    op_i = MUL; a_i = 32'd5; b_i = 32'd5; start_i = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 3) a_i = 32'd99;
      #1;
      if (done_o === 1'b1) begin
        dones++; lo = res_lo_o; start_i = 1'b0;
        if (done_at == 0) done_at = c;
      end
    end
    start_i = 1'b0;
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", dones); end
    n_checks++; if (done_at != 35) begin n_fail++; $display("FAIL b2b_latency: got %0d want 35", done_at); end
    n_checks++; if (lo !== 32'd25) begin n_fail++; $display("FAIL b2b_lo: got %h want 00000019", lo); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_wide();
    test_div();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
